// File: rtl/word_store_unit.sv
// Byte-serial word transfer engine: stores a word as consecutive byte writes
// or loads consecutive byte reads back into a word.
module word_store_unit #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 16,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic [7:0]              mem_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    busy,
    output logic                    done
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int KW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [KW-1:0]     k;
    logic [KW-1:0]     k_n;
    logic [KW-1:0]     rd_k;
    logic [KW-1:0]     rd_k_n;
    logic              rd_pend;
    logic              rd_pend_n;
    logic              mode_q;
    logic              mode_n;
    logic [W-1:0]      word_q;
    logic [W-1:0]      word_n;
    logic [W-1:0]      asm_q;
    logic [W-1:0]      asm_n;
    logic [W-1:0]      word_out_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic              we_n;
    logic              re_n;
    logic              busy_n;
    logic              done_n;

    // Byte lane touched by access idx; loads mirror the store lane order.
    function automatic int lane(input logic [KW-1:0] idx);
        return LSB_FIRST ? int'(idx) : WORD_BYTES - 1 - int'(idx);
    endfunction

    function automatic logic [7:0] pick(input logic [W-1:0] w, input int ln);
        logic [W-1:0] t;
        t = w >> (8 * ln);
        return t[7:0];
    endfunction

    function automatic logic [W-1:0] merge(input logic [W-1:0] a,
                                           input int ln,
                                           input logic [7:0] b);
        logic [W-1:0] m;
        m = W'(8'hFF) << (8 * ln);
        return (a & ~m) | (W'(b) << (8 * ln));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            rd_k      <= '0;
            rd_pend   <= 1'b0;
            mode_q    <= 1'b0;
            word_q    <= '0;
            asm_q     <= '0;
            word_out  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            rd_k      <= rd_k_n;
            rd_pend   <= rd_pend_n;
            mode_q    <= mode_n;
            word_q    <= word_n;
            asm_q     <= asm_n;
            word_out  <= word_out_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= we_n;
            mem_re    <= re_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = XFER;
            XFER:  if (k == K_LAST) state_n = mode_q ? DRAIN : DONE;
            DRAIN: state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered.
    always_comb begin
        k_n        = k;
        mode_n     = mode_q;
        word_n     = word_q;
        asm_n      = asm_q;
        word_out_n = word_out;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        we_n       = 1'b0;
        re_n       = 1'b0;
        rd_pend_n  = mem_re;
        rd_k_n     = k;
        busy_n     = (state_n != IDLE);
        done_n     = (state_n == DONE);

        // Read data lands one cycle after its strobe.
        if (rd_pend) begin
            asm_n = merge(asm_q, lane(rd_k), mem_rdata);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    mode_n  = mode;
                    word_n  = word_in;
                    k_n     = '0;
                    addr_n  = base_addr;
                    we_n    = ~mode;
                    re_n    = mode;
                    wdata_n = pick(word_in, lane('0));
                end
            end
            XFER: begin
                if (k != K_LAST) begin
                    k_n     = k + KW'(1);
                    addr_n  = mem_addr + ADDR_W'(1);
                    we_n    = ~mode_q;
                    re_n    = mode_q;
                    wdata_n = pick(word_q, lane(k + KW'(1)));
                end
            end
            default: begin
            end
        endcase

        if (state_n == DONE && mode_q) begin
            word_out_n = asm_n;
        end
    end

endmodule

// File: tb/tb_word_store_unit.sv
// Scoreboard bench for word_store_unit over four parameter sets.
// Stimulus queues expected bus events; a negedge monitor pops and compares.
module tb_word_store_unit;

    localparam int K_RST  = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_DONE = 3;
    localparam int K_IDLE = 4;

    // {we, re, busy, done}
    localparam logic [3:0] F_WR = 4'b1010;
    localparam logic [3:0] F_RD = 4'b0110;
    localparam logic [3:0] F_DN = 4'b0011;
    localparam logic [3:0] F_Z  = 4'b0000;

    typedef struct {
        int          inst;
        int          cyc;
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [63:0] wout;
        logic [3:0]  flg;
    } ev_t;

    ev_t expq[$];

    logic        clk;
    logic        rst_n;
    logic [3:0]  start_v;
    logic [3:0]  mode_v;
    logic [15:0] base_v [4];
    logic [63:0] win_v [4];
    logic [7:0]  rdata_v [4];
    logic [15:0] addr_v [4];
    logic [7:0]  wdata_v [4];
    logic [3:0]  we_v;
    logic [3:0]  re_v;
    logic [63:0] wout_v [4];
    logic [3:0]  busy_v;
    logic [3:0]  done_v;

    logic [7:0]  mem [0:65535];
    int          cyc;
    logic        rst_last;
    logic [3:0]  prev_busy;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NB = (g == 0) ? 2 : (g == 3) ? 1 : 4;
        localparam bit LF = (g == 1) ? 1'b0 : 1'b1;
        logic [8*NB-1:0] wo;
        word_store_unit #(
            .WORD_BYTES(NB),
            .ADDR_W(16),
            .LSB_FIRST(LF)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start_v[g]),
            .mode(mode_v[g]),
            .base_addr(base_v[g]),
            .word_in(win_v[g][8*NB-1:0]),
            .mem_rdata(rdata_v[g]),
            .mem_addr(addr_v[g]),
            .mem_wdata(wdata_v[g]),
            .mem_we(we_v[g]),
            .mem_re(re_v[g]),
            .word_out(wo),
            .busy(busy_v[g]),
            .done(done_v[g])
        );
        assign wout_v[g] = 64'(wo);
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_last <= !rst_n;
        for (int i = 0; i < 4; i++) rdata_v[i] <= mem[addr_v[i]];
    end

    function automatic string kname(input int k);
        case (k)
            K_RST:  return "reset";
            K_WR:   return "write";
            K_RD:   return "read";
            K_DONE: return "done";
            default: return "idle";
        endcase
    endfunction

    task automatic observe(input int i, input int k, input logic [15:0] a,
                           input logic [7:0] d, input logic [63:0] wo,
                           input logic [3:0] f);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s inst%0d cyc=%0d got addr=%h data=%h wout=%h flg=%b, required no event",
                     kname(k), i, cyc, a, d, wo, f);
        end else begin
            e = expq.pop_front();
            if (e.inst != i || e.cyc != cyc || e.kind != k || e.addr !== a ||
                e.data !== d || e.wout !== wo || e.flg !== f) begin
                errors++;
                $display("FAIL %s inst%0d: got cyc=%0d kind=%s addr=%h data=%h wout=%h flg=%b, required inst%0d cyc=%0d kind=%s addr=%h data=%h wout=%h flg=%b",
                         kname(e.kind), i, cyc, kname(k), a, d, wo, f,
                         e.inst, e.cyc, kname(e.kind), e.addr, e.data, e.wout, e.flg);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_last) begin
                observe(i, K_RST, addr_v[i], wdata_v[i], wout_v[i],
                        {we_v[i], re_v[i], busy_v[i], done_v[i]});
            end else begin
                if (we_v[i])
                    observe(i, K_WR, addr_v[i], wdata_v[i], 64'd0,
                            {we_v[i], re_v[i], busy_v[i], done_v[i]});
                if (re_v[i])
                    observe(i, K_RD, addr_v[i], 8'd0, 64'd0,
                            {we_v[i], re_v[i], busy_v[i], done_v[i]});
                if (done_v[i])
                    observe(i, K_DONE, 16'd0, 8'd0, wout_v[i],
                            {we_v[i], re_v[i], busy_v[i], done_v[i]});
                if (prev_busy[i] && !busy_v[i])
                    observe(i, K_IDLE, 16'd0, 8'd0, 64'd0,
                            {we_v[i], re_v[i], busy_v[i], done_v[i]});
            end
            prev_busy[i] = busy_v[i];
        end
    end

    task automatic ex(input int i, input int c, input int k,
                      input logic [15:0] a, input logic [7:0] d,
                      input logic [63:0] wo, input logic [3:0] f);
        ev_t e;
        e.inst = i;
        e.cyc  = c;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.wout = wo;
        e.flg  = f;
        expq.push_back(e);
    endtask

    // Called just after a rising edge; returns one cycle later.
    task automatic go(input int i, input logic m, input logic [15:0] b,
                      input logic [63:0] w);
        start_v[i] = 1'b1;
        mode_v[i]  = m;
        base_v[i]  = b;
        win_v[i]   = w;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        cyc       = 0;
        rst_last  = 1'b0;
        prev_busy = 4'b0;
        checks    = 0;
        errors    = 0;
        start_v   = 4'b0;
        mode_v    = 4'b0;
        for (int i = 0; i < 4; i++) begin
            base_v[i] = 16'd0;
            win_v[i]  = 64'd0;
        end
        mem[16'h0200] = 8'h12;
        mem[16'h0201] = 8'h34;
        mem[16'h0202] = 8'h56;
        mem[16'h0203] = 8'h78;
        mem[16'h0300] = 8'hCA;
        mem[16'h0301] = 8'hFE;
        mem[16'h0302] = 8'hBA;
        mem[16'h0303] = 8'hBE;
        mem[16'h0500] = 8'h11;
        mem[16'h0501] = 8'h22;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) ex(i, 1, K_RST, 16'h0, 8'h0, 64'h0, F_Z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // N=2 LSB-first store
        c = cyc;
        ex(0, c + 1, K_WR, 16'h0010, 8'hEF, 64'h0, F_WR);
        ex(0, c + 2, K_WR, 16'h0011, 8'hBE, 64'h0, F_WR);
        ex(0, c + 3, K_DONE, 16'h0, 8'h0, 64'h0, F_DN);
        ex(0, c + 4, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        go(0, 1'b0, 16'h0010, 64'hBEEF);
        idle(6);

        // N=2 LSB-first load
        c = cyc;
        ex(0, c + 1, K_RD, 16'h0500, 8'h0, 64'h0, F_RD);
        ex(0, c + 2, K_RD, 16'h0501, 8'h0, 64'h0, F_RD);
        ex(0, c + 4, K_DONE, 16'h0, 8'h0, 64'h2211, F_DN);
        ex(0, c + 5, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        go(0, 1'b1, 16'h0500, 64'h0);
        idle(6);

        // N=4 MSB-first load
        c = cyc;
        ex(1, c + 1, K_RD, 16'h0200, 8'h0, 64'h0, F_RD);
        ex(1, c + 2, K_RD, 16'h0201, 8'h0, 64'h0, F_RD);
        ex(1, c + 3, K_RD, 16'h0202, 8'h0, 64'h0, F_RD);
        ex(1, c + 4, K_RD, 16'h0203, 8'h0, 64'h0, F_RD);
        ex(1, c + 6, K_DONE, 16'h0, 8'h0, 64'h12345678, F_DN);
        ex(1, c + 7, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        go(1, 1'b1, 16'h0200, 64'h0);
        idle(9);

        // N=4 store wrapping past 0xFFFF
        c = cyc;
        ex(2, c + 1, K_WR, 16'hFFFE, 8'hD4, 64'h0, F_WR);
        ex(2, c + 2, K_WR, 16'hFFFF, 8'hC3, 64'h0, F_WR);
        ex(2, c + 3, K_WR, 16'h0000, 8'hB2, 64'h0, F_WR);
        ex(2, c + 4, K_WR, 16'h0001, 8'hA1, 64'h0, F_WR);
        ex(2, c + 5, K_DONE, 16'h0, 8'h0, 64'h0, F_DN);
        ex(2, c + 6, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        go(2, 1'b0, 16'hFFFE, 64'hA1B2C3D4);
        idle(8);

        // start held high, word_in changed mid-transfer
        c = cyc;
        ex(0, c + 1, K_WR, 16'h0040, 8'h34, 64'h0, F_WR);
        ex(0, c + 2, K_WR, 16'h0041, 8'h12, 64'h0, F_WR);
        ex(0, c + 3, K_DONE, 16'h0, 8'h0, 64'h2211, F_DN);
        ex(0, c + 4, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        ex(0, c + 5, K_WR, 16'h0040, 8'hCD, 64'h0, F_WR);
        ex(0, c + 6, K_WR, 16'h0041, 8'hAB, 64'h0, F_WR);
        ex(0, c + 7, K_DONE, 16'h0, 8'h0, 64'h2211, F_DN);
        ex(0, c + 8, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        start_v[0] = 1'b1;
        mode_v[0]  = 1'b0;
        base_v[0]  = 16'h0040;
        win_v[0]   = 64'h1234;
        idle(1);
        win_v[0]   = 64'hABCD;
        idle(4);
        start_v[0] = 1'b0;
        idle(8);

        // completed load, then reset in cycle 2 of the next load
        c = cyc;
        ex(1, c + 1, K_RD, 16'h0300, 8'h0, 64'h0, F_RD);
        ex(1, c + 2, K_RD, 16'h0301, 8'h0, 64'h0, F_RD);
        ex(1, c + 3, K_RD, 16'h0302, 8'h0, 64'h0, F_RD);
        ex(1, c + 4, K_RD, 16'h0303, 8'h0, 64'h0, F_RD);
        ex(1, c + 6, K_DONE, 16'h0, 8'h0, 64'hCAFEBABE, F_DN);
        ex(1, c + 7, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        go(1, 1'b1, 16'h0300, 64'h0);
        idle(9);
        c = cyc;
        ex(1, c + 1, K_RD, 16'h0300, 8'h0, 64'h0, F_RD);
        ex(1, c + 2, K_RD, 16'h0301, 8'h0, 64'h0, F_RD);
        for (int i = 0; i < 4; i++) ex(i, c + 3, K_RST, 16'h0, 8'h0, 64'h0, F_Z);
        go(1, 1'b1, 16'h0300, 64'h0);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(6);

        // N=1 store
        c = cyc;
        ex(3, c + 1, K_WR, 16'h0007, 8'h5A, 64'h0, F_WR);
        ex(3, c + 2, K_DONE, 16'h0, 8'h0, 64'h0, F_DN);
        ex(3, c + 3, K_IDLE, 16'h0, 8'h0, 64'h0, F_Z);
        go(3, 1'b0, 16'h0007, 64'h5A);
        idle(5);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d expected events never seen, required 0",
                     expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_store_unit.md
# word_store_unit

Parametrised word/memory transfer engine for the processor's control path. It serialises a multi-byte word, such as a program counter or other context register, into consecutive byte writes to data memory. It also deserialises consecutive byte reads back into a word. This generalises the fixed two-byte PC store to any byte count, either byte order, and adds a load (restore) mode, explicit addressing and a start/busy/done handshake.

## Interface
- WORD_BYTES, 2, bytes per word (N); legal range 1..8
- ADDR_W, 16, memory byte-address width
- LSB_FIRST, 1, 1: byte 0 (bits 7:0) goes to the lowest address; 0: most-significant byte goes to the lowest address

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request a transfer; sampled only when busy=0
- mode  in  1  0 = store (word→memory), 1 = load (memory→word); sampled with start
- base_addr  in  ADDR_W  address of first byte; sampled with start
- word_in  in  8*N  word to store; sampled with start
- mem_rdata  in  8  read data, valid exactly one cycle after the mem_re cycle
- mem_addr  out  ADDR_W  byte address for current access
- mem_wdata  out  8  write byte
- mem_we  out  1  write strobe, one byte per cycle
- mem_re  out  1  read strobe
- word_out  out  8*N  last loaded word; holds until the next load completes
- busy  out  1  transfer in progress (including done cycle)
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, XFER, DRAIN (load only), DONE.
- IDLE: if start=1, latch mode, base_addr and word_in, clear byte index k, and go to XFER. Otherwise remain in IDLE.
- XFER: issue access k at address base_addr+k; k counts 0..N-1.
  - Byte selected: LSB_FIRST=1 → word[8k+7:8k]; LSB_FIRST=0 → word[8(N-1-k)+7:8(N-1-k)].
  - Store: mem_we=1, mem_wdata=selected byte.
  - Load: mem_re=1.
  - After k=N-1: store goes to DONE; load goes to DRAIN.
- DRAIN: capture the final read byte, then go to DONE.
- Load capture: the mem_rdata returned for access k is written into the byte lane that access k would have written in store mode. The assembly register is internal; word_out updates from it only on entry to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Address arithmetic: base_addr+k is computed modulo 2^ADDR_W. Wrap from all-ones to 0 is legal and silent.
- start while busy=1 is ignored. It is not queued.
- mem_we and mem_re are never both high. Both are 0 outside XFER.
- N=1: a single access; all other rules unchanged.

## Timing
- All outputs are registered. Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Store: access k appears in cycle k+1 (k = 0..N-1). done=1 in cycle N+1. busy=1 in cycles 1..N+1.
- Load: mem_re for access k in cycle k+1. Data is captured at the end of cycle k+2. word_out becomes valid and done=1 in cycle N+2. busy=1 in cycles 1..N+2.
- Earliest next start is sampled in the cycle after done.
- Reset values (rst_n=0 at an edge): state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, word_out=0, busy=0, done=0, k=0.
- Reset mid-transfer: all outputs take reset values in the next cycle. No further strobes are issued. A partial load does not update word_out.
- Inputs other than start and rst_n are don't-care while busy=1.

## Test plan
- Store, defaults, base=0x0010, word_in=0xBEEF → cycle1: we, addr 0x0010, data 0xEF; cycle2: we, addr 0x0011, data 0xBE; cycle3: done=1; cycle4: busy=0.
- Load, LSB_FIRST=0, N=4, base=0x0200, memory bytes 0x12,0x34,0x56,0x78 at 0x0200..0x0203 → re in cycles 1..4; word_out=0x12345678 with done in cycle 6.
- Wrap: store with N=4, base=0xFFFE, word_in=0xA1B2C3D4 → writes 0xD4@0xFFFE, 0xC3@0xFFFF, 0xB2@0x0000, 0xA1@0x0001.
- start held high during a store, with word_in changed mid-transfer → exactly 2 writes carrying the originally latched bytes. A second transfer begins with cycle 1 following the cycle after done.
- Reset asserted in cycle 2 of an N=4 load preceded by a completed load of 0xCAFE… → next cycle: all outputs 0, including word_out. No strobes until a new start.
- N=1 store of 0x5A at base 0x0007 → one write in cycle 1 (0x5A@0x0007), done in cycle 2.
